// File: rtl/vpu_max_reduce_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vpu_max_reduce_ctrl_pkg
// Shared definitions for the VPU signed-max reduction sequencer:
//   - OPERAND_WIDTH    : native VPU element width
//   - MAX_REDUCE_LANES : elements carried per input beat
//   - SI_MIN_OPERAND   : most negative two's-complement OPERAND_WIDTH value
//   - max_reduce_state_t : sequencer FSM encoding
// -----------------------------------------------------------------------------
package vpu_max_reduce_ctrl_pkg;

  localparam int OPERAND_WIDTH    = 32;
  localparam int MAX_REDUCE_LANES = 2;

  localparam logic [OPERAND_WIDTH-1:0] SI_MIN_OPERAND =
    {1'b1, {(OPERAND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_RUN  = 2'd1,
    MR_DONE = 2'd2
  } max_reduce_state_t;

endpackage

// File: rtl/vpu_max_reduce_ctrl_alu.sv
// -----------------------------------------------------------------------------
// vpu_max_reduce_ctrl_alu
// Combinational three-operand signed-max ALU (the VPU SI_MAX function).
// Ties resolve to the lowest-numbered operand, so op_0 beats op_1 beats op_2.
//
// Ports:
//   en        in  1        : result is forced to zero when low
//   op_0..2   in  DATA_W   : two's-complement operands
//   op_valid  in  3        : per-operand participation mask
//   result    out DATA_W   : signed maximum of the participating operands
// -----------------------------------------------------------------------------
module vpu_max_reduce_ctrl_alu #(
  parameter int DATA_W = 32
) (
  input  logic              en,
  input  logic [DATA_W-1:0] op_0,
  input  logic [DATA_W-1:0] op_1,
  input  logic [DATA_W-1:0] op_2,
  input  logic [2:0]        op_valid,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] best_01;
  logic [DATA_W-1:0] best_012;
  logic              have_01;

  // NOTE: every variable assigned in an always_comb gets a default on the
  // first lines so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    best_01  = op_0;
    have_01  = op_valid[0];
    // Strict compare keeps the earlier operand on a tie.
    if (op_valid[1] && (!have_01 || ($signed(op_1) > $signed(best_01)))) begin
      best_01 = op_1;
    end
    have_01  = op_valid[0] | op_valid[1];

    best_012 = best_01;
    if (op_valid[2] && (!have_01 || ($signed(op_2) > $signed(best_01)))) begin
      best_012 = op_2;
    end

    result = en ? best_012 : '0;
  end

endmodule

// File: rtl/vpu_max_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// vpu_max_reduce_ctrl
// Signed-integer max reduction over a streamed vector of arbitrary length.
// Each input beat carries up to two elements; the running accumulator and the
// new lanes share one pass through the signed-max ALU per accepted beat.
//
// Optional feature: define VPU_MAX_REDUCE_ARGMAX_EN to add out_idx_o, the
// zero-based position of the maximum (earliest index wins ties).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : start pulse, honoured only when idle
//   len_i        : element count, captured with start_i
//   busy_o       : high while a reduction is running or its result is pending
//   in_valid_i / in_ready_o / in_data_i / in_cnt_i : element stream
//                  (lane0 = low half, older element; in_cnt_i = valid lanes)
//   out_valid_o / out_ready_i / out_data_o : result handshake
//   out_empty_o  : result came from a zero-length reduction
//   out_idx_o    : argmax index (VPU_MAX_REDUCE_ARGMAX_EN only)
// -----------------------------------------------------------------------------
module vpu_max_reduce_ctrl
  import vpu_max_reduce_ctrl_pkg::*;
#(
  parameter int DATA_W = OPERAND_WIDTH,
  parameter int LEN_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [LEN_W-1:0]                   len_i,
  output logic                               busy_o,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [MAX_REDUCE_LANES*DATA_W-1:0] in_data_i,
  input  logic [1:0]                         in_cnt_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_W-1:0]                  out_data_o,
  output logic                               out_empty_o
`ifdef VPU_MAX_REDUCE_ARGMAX_EN
  ,
  output logic [LEN_W-1:0]                   out_idx_o
`endif
);

  localparam logic [DATA_W-1:0] SI_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  max_reduce_state_t state, state_nxt;

  logic [DATA_W-1:0] acc;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  rem_nxt;
  logic [1:0]        eff_cnt;
  logic [1:0]        use_cnt;
  logic              beat_hs;
  logic              beat_upd;
  logic              last_beat;
  logic [DATA_W-1:0] lane0;
  logic [DATA_W-1:0] lane1;
  logic [DATA_W-1:0] alu_result;

  assign lane0 = in_data_i[DATA_W-1:0];
  assign lane1 = in_data_i[2*DATA_W-1:DATA_W];

  // Elements consumed by this beat: in_cnt_i saturates at two lanes and is
  // further clipped to what remains, so rem can never wrap.
  always_comb begin
    eff_cnt = in_cnt_i[1] ? 2'd2 : in_cnt_i;
    use_cnt = (rem >= LEN_W'(eff_cnt)) ? eff_cnt : rem[1:0];
  end

  assign beat_hs   = in_valid_i && in_ready_o;
  // A zero-lane beat is consumed without touching acc or rem.
  assign beat_upd  = beat_hs && (use_cnt != 2'd0);
  assign rem_nxt   = rem - LEN_W'(use_cnt);
  assign last_beat = beat_upd && (rem_nxt == '0);

  vpu_max_reduce_ctrl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .en       (beat_hs),
    .op_0     (acc),
    .op_1     (lane0),
    .op_2     (lane1),
    .op_valid ({use_cnt == 2'd2, 1'b1, 1'b1}),
    .result   (alu_result)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) is reserved for combinational blocks.
  always_ff @(posedge clk) begin
    if (rst) state <= MR_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      MR_IDLE: if (start_i)     state_nxt = (len_i != '0) ? MR_RUN : MR_DONE;
      MR_RUN:  if (last_beat)   state_nxt = MR_DONE;
      MR_DONE: if (out_ready_i) state_nxt = MR_IDLE;
      default:                  state_nxt = MR_IDLE;
    endcase
  end

  // FSM: outputs (pure functions of the registered state)
  always_comb begin
    busy_o      = (state != MR_IDLE);
    in_ready_o  = (state == MR_RUN);
    out_valid_o = (state == MR_DONE);
  end

`ifdef VPU_MAX_REDUCE_ARGMAX_EN
  // ---------------------------------------------------------------------------
  // Argmax tracking: elem_cnt is the index of lane0 in the current beat.
  // Strict compares keep the earliest index on ties.
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0]  elem_cnt;
  logic [LEN_W-1:0]  idx_acc;
  logic [LEN_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] best_acc_l0;

  always_comb begin
    idx_nxt     = idx_acc;
    best_acc_l0 = acc;
    if ($signed(lane0) > $signed(acc)) begin
      idx_nxt     = elem_cnt;
      best_acc_l0 = lane0;
    end
    if ((use_cnt == 2'd2) && ($signed(lane1) > $signed(best_acc_l0))) begin
      idx_nxt = elem_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt  <= '0;
      idx_acc   <= '0;
      out_idx_o <= '0;
    end else begin
      unique case (state)
        MR_IDLE: begin
          if (start_i) begin
            elem_cnt <= '0;
            idx_acc  <= '0;
            if (len_i == '0) out_idx_o <= '0;
          end
        end
        MR_RUN: begin
          if (beat_upd) begin
            elem_cnt <= elem_cnt + LEN_W'(use_cnt);
            idx_acc  <= idx_nxt;
            if (last_beat) out_idx_o <= idx_nxt;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Accumulator, remaining count and registered result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      rem         <= '0;
      out_data_o  <= '0;
      out_empty_o <= 1'b0;
    end else begin
      unique case (state)
        MR_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              rem         <= len_i;
              acc         <= SI_MIN;
              out_empty_o <= 1'b0;
            end else begin
              out_data_o  <= SI_MIN;
              out_empty_o <= 1'b1;
            end
          end
        end
        MR_RUN: begin
          if (beat_upd) begin
            acc <= alu_result;
            rem <= rem_nxt;
            if (last_beat) out_data_o <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_max_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vpu_max_reduce_ctrl
// Directed self-checking bench for vpu_max_reduce_ctrl. Inputs are driven and
// outputs sampled 1 ns after each rising edge. Argmax checks are compiled in
// when VPU_MAX_REDUCE_ARGMAX_EN is defined.
// -----------------------------------------------------------------------------
module tb_vpu_max_reduce_ctrl;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [2*DATA_W-1:0] in_data_i;
  logic [1:0]        in_cnt_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_empty_o;
`ifdef VPU_MAX_REDUCE_ARGMAX_EN
  logic [LEN_W-1:0]  out_idx_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vpu_max_reduce_ctrl #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_cnt_i    (in_cnt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_empty_o (out_empty_o)
`ifdef VPU_MAX_REDUCE_ARGMAX_EN
    ,
    .out_idx_o   (out_idx_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start_i = 1'b1;
    len_i   = LEN_W'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic beat(input int lo, input int hi, input logic [1:0] cnt);
    in_valid_i = 1'b1;
    in_data_i  = {hi, lo};
    in_cnt_i   = cnt;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int data, input logic empty, input int idx);
    check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    check({tag, "_data"},  64'(out_data_o),  64'(unsigned'(data)));
    check({tag, "_empty"}, 64'(out_empty_o), 64'(empty));
`ifdef VPU_MAX_REDUCE_ARGMAX_EN
    check({tag, "_idx"},   64'(out_idx_o),   64'(idx));
`else
    if (idx < 0) $display("unexpected negative index %0d", idx);
`endif
  endtask

  task automatic accept_result();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0; in_valid_i = 1'b0;
    in_data_i = '0; in_cnt_i = '0; out_ready_i = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_in_ready",  64'(in_ready_o),  64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data",  64'(out_data_o),  64'd0);
    check("rst_out_empty", 64'(out_empty_o), 64'd0);
    rst = 1'b0;
    tick();

    // Test 1: len=5, last beat's lane1 discarded, max 12 at index 2
    do_start(5);
    check("t1_in_ready", 64'(in_ready_o), 64'd1);
    check("t1_busy",     64'(busy_o),     64'd1);
    beat(3, -7, 2'd2);
    check("t1_b1_valid", 64'(out_valid_o), 64'd0);
    beat(12, 12, 2'd2);
    check("t1_b2_valid", 64'(out_valid_o), 64'd0);
    beat(-1, 55, 2'd2);
    check_result("t1", 12, 1'b0, 2);
    check("t1_done_in_ready", 64'(in_ready_o), 64'd0);
    accept_result();
    check("t1_idle_busy", 64'(busy_o), 64'd0);

    // Test 2: len=0 completes the next cycle with SI_MIN and empty
    do_start(0);
    check_result("t2", 32'sh8000_0000, 1'b1, 0);
    check("t2_in_ready", 64'(in_ready_o), 64'd0);
    accept_result();

    // Test 3: every element is the minimum value; empty must clear
    do_start(4);
    beat(32'sh8000_0000, 32'sh8000_0000, 2'd2);
    beat(32'sh8000_0000, 32'sh8000_0000, 2'd3);
    check_result("t3", 32'sh8000_0000, 1'b0, 0);
    accept_result();

    // Test 4: gaps, a zero-lane beat, excess lane, output backpressure.
    // Elements 5,-3,100,-100,7,100,50 -> max 100 first seen at index 2.
    do_start(7);
    beat(5, -3, 2'd2);
    tick();
    check("t4_gap_in_ready", 64'(in_ready_o), 64'd1);
    beat(999, 999, 2'd0);
    beat(100, -100, 2'd2);
    tick(); tick();
    check("t4_gap_valid", 64'(out_valid_o), 64'd0);
    beat(7, 100, 2'd2);
    beat(50, 200, 2'd2);
    check_result("t4", 100, 1'b0, 2);
    in_valid_i = 1'b1;
    in_data_i  = {32'sd500, 32'sd500};
    in_cnt_i   = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid",    64'(out_valid_o), 64'd1);
      check("t4_hold_data",     64'(out_data_o),  64'd100);
      check("t4_hold_in_ready", 64'(in_ready_o),  64'd0);
    end
    in_valid_i = 1'b0;
    accept_result();
    check("t4_idle_valid", 64'(out_valid_o), 64'd0);

    // Test 5: reset on the second beat, then a fresh len=1 run
    do_start(6);
    beat(1, 2, 2'd2);
    rst = 1'b1;
    beat(3, 4, 2'd2);
    rst = 1'b0;
    check("t5_rst_busy",      64'(busy_o),      64'd0);
    check("t5_rst_in_ready",  64'(in_ready_o),  64'd0);
    check("t5_rst_out_valid", 64'(out_valid_o), 64'd0);
    check("t5_rst_out_data",  64'(out_data_o),  64'd0);
    check("t5_rst_out_empty", 64'(out_empty_o), 64'd0);
    do_start(1);
    beat(9, 77, 2'd2);
    check_result("t5", 9, 1'b0, 0);
    accept_result();

    // Test 6: start while running and with the output handshake is ignored
    do_start(2);
    start_i = 1'b1; len_i = '0;
    tick();
    start_i = 1'b0;
    check("t6_run_busy",     64'(busy_o),      64'd1);
    check("t6_run_in_ready", 64'(in_ready_o),  64'd1);
    check("t6_run_valid",    64'(out_valid_o), 64'd0);
    beat(-4, -6, 2'd2);
    check_result("t6", -4, 1'b0, 0);
    start_i = 1'b1; len_i = LEN_W'(3);
    accept_result();
    start_i = 1'b0;
    check("t6_idle_busy",  64'(busy_o),      64'd0);
    check("t6_idle_valid", 64'(out_valid_o), 64'd0);
    tick();
    check("t6_still_idle", 64'(busy_o),      64'd0);

    // Test 7: single-lane beat then in_cnt=3 saturating to two lanes.
    // Elements -5,-8,-2 -> max -2 at index 2.
    do_start(3);
    beat(-5, 1000, 2'd1);
    check("t7_b1_valid", 64'(out_valid_o), 64'd0);
    beat(-8, -2, 2'd3);
    check_result("t7", -2, 1'b0, 2);
    accept_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
